// File: rtl/draw_sequencer.sv
// draw_sequencer: FSM plus datapath that turns a block request (origin x/y and
// colour) or a full-screen clear request into a raster of pixel writes, one
// per cycle, toward the VGA adapter. Off-screen block pixels still take their
// cycle but are not written. A clear that arrives while busy is remembered and
// runs next. A one-cycle done pulse marks the end of each operation.
// Optional build macro: PLOT_STALL_EN adds a plot_ready back-pressure input.
module draw_sequencer #(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int COLOUR_W     = 3,
  parameter int SCR_W        = 160,
  parameter int SCR_H        = 120,
  parameter int BLK_W        = 4,
  parameter int BLK_H        = 4,
  parameter int CLEAR_COLOUR = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable_start,
  input  logic                enable_clear,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
`ifdef PLOT_STALL_EN
  input  logic                plot_ready,
`endif
  output logic                ready_to_draw,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                writeEn,
  output logic                done
);

  // Column/row counters are shared by block and clear scans; the clear scan
  // covers the whole screen, so its extent sets the width.
  localparam int CW   = (SCR_W > 1) ? $clog2(SCR_W) : 1;
  localparam int RW   = (SCR_H > 1) ? $clog2(SCR_H) : 1;
  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;

  localparam logic [CW-1:0]   BLK_COL_LAST = CW'(BLK_W - 1);
  localparam logic [RW-1:0]   BLK_ROW_LAST = RW'(BLK_H - 1);
  localparam logic [CW-1:0]   SCR_COL_LAST = CW'(SCR_W - 1);
  localparam logic [RW-1:0]   SCR_ROW_LAST = RW'(SCR_H - 1);
  localparam logic [XS_W-1:0] SCR_W_X      = XS_W'(SCR_W);
  localparam logic [YS_W-1:0] SCR_H_Y      = YS_W'(SCR_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW_BLOCK,
    S_LOAD_CLEAR,
    S_DRAW_CLEAR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                clearPending_q, clearPending_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [X_W-1:0]      xOut_q, xOut_d;
  logic [Y_W-1:0]      yOut_q, yOut_d;
  logic [COLOUR_W-1:0] colourOut_q, colourOut_d;
  logic                writeEn_q, writeEn_d;
  logic                done_q, done_d;

  logic [XS_W-1:0]     xSum;
  logic [YS_W-1:0]     ySum;
  logic [CW-1:0]       colLast;
  logic [RW-1:0]       rowLast;
  logic                stall;

  // One bit wider than the coordinate so that an off-screen sum never wraps
  // back onto the screen.
  assign xSum = {1'b0, x0_q} + XS_W'(col_q);
  assign ySum = {1'b0, y0_q} + YS_W'(row_q);

  assign colLast = (state_q == S_DRAW_BLOCK) ? BLK_COL_LAST : SCR_COL_LAST;
  assign rowLast = (state_q == S_DRAW_BLOCK) ? BLK_ROW_LAST : SCR_ROW_LAST;

`ifdef PLOT_STALL_EN
  assign stall = writeEn_q & ~plot_ready;
`else
  assign stall = 1'b0;
`endif

  assign ready_to_draw = (state_q == S_IDLE) && !clearPending_q;
  assign x_out         = xOut_q;
  assign y_out         = yOut_q;
  assign colour_out    = colourOut_q;
  assign writeEn       = writeEn_q;
  assign done          = done_q;

  // Next-state and next-pixel logic; a stalled write freezes everything except
  // the capture of a new clear request.
  always_comb begin
    state_d        = state_q;
    clearPending_d = clearPending_q;
    col_d          = col_q;
    row_d          = row_q;
    x0_d           = x0_q;
    y0_d           = y0_q;
    colour_d       = colour_q;
    xOut_d         = xOut_q;
    yOut_d         = yOut_q;
    colourOut_d    = colourOut_q;
    writeEn_d      = 1'b0;
    done_d         = 1'b0;

    if (enable_clear && (state_q != S_IDLE)) begin
      clearPending_d = 1'b1;
    end

    if (stall) begin
      writeEn_d = writeEn_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_start && !clearPending_q) begin
            state_d = S_LOAD;
            if (enable_clear) begin
              clearPending_d = 1'b1;
            end
          end else if (enable_clear || clearPending_q) begin
            state_d = S_LOAD_CLEAR;
          end
        end
        S_LOAD: begin
          x0_d     = x_in;
          y0_d     = y_in;
          colour_d = colour_in;
          col_d    = '0;
          row_d    = '0;
          state_d  = S_DRAW_BLOCK;
        end
        S_DRAW_BLOCK: begin
          xOut_d      = xSum[X_W-1:0];
          yOut_d      = ySum[Y_W-1:0];
          colourOut_d = colour_q;
          writeEn_d   = (xSum < SCR_W_X) && (ySum < SCR_H_Y);
        end
        S_LOAD_CLEAR: begin
          clearPending_d = 1'b0;
          col_d          = '0;
          row_d          = '0;
          state_d        = S_DRAW_CLEAR;
        end
        S_DRAW_CLEAR: begin
          xOut_d      = X_W'(col_q);
          yOut_d      = Y_W'(row_q);
          colourOut_d = COLOUR_W'(CLEAR_COLOUR);
          writeEn_d   = 1'b1;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if ((state_q == S_DRAW_BLOCK) || (state_q == S_DRAW_CLEAR)) begin
        if (col_q == colLast) begin
          col_d = '0;
          if (row_q == rowLast) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      clearPending_q <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      x0_q           <= '0;
      y0_q           <= '0;
      colour_q       <= '0;
      xOut_q         <= '0;
      yOut_q         <= '0;
      colourOut_q    <= '0;
      writeEn_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      clearPending_q <= clearPending_d;
      col_q          <= col_d;
      row_q          <= row_d;
      x0_q           <= x0_d;
      y0_q           <= y0_d;
      colour_q       <= colour_d;
      xOut_q         <= xOut_d;
      yOut_q         <= yOut_d;
      colourOut_q    <= colourOut_d;
      writeEn_q      <= writeEn_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: scoreboard bench for draw_sequencer. Requests push the
// pixels and done pulses they should produce into a queue; a monitor pops and
// compares every consumed write and every done pulse.
module tb_draw_sequencer;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int BLK_W = 4;
  localparam int BLK_H = 4;

  typedef struct {
    bit isDone;
    int x;
    int y;
    int c;
  } item_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable_start = 1'b0;
  logic       enable_clear = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       plot_ready = 1'b1;
  logic       ready_to_draw;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       writeEn;
  logic       done;

  item_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    nWrites = 0;

  draw_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable_start (enable_start),
    .enable_clear (enable_clear),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
`ifdef PLOT_STALL_EN
    .plot_ready   (plot_ready),
`endif
    .ready_to_draw(ready_to_draw),
    .x_out        (x_out),
    .y_out        (y_out),
    .colour_out   (colour_out),
    .writeEn      (writeEn),
    .done         (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Abort if the run never completes.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: compare each consumed write and each done pulse to the queue head.
  always @(negedge clk) begin
    item_t e;
    if (resetn) begin
      if (writeEn && plot_ready) begin
        nWrites++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL pixel got (%0d,%0d,%0d) want no write", x_out, y_out, colour_out);
        end else begin
          e = sb.pop_front();
          if (e.isDone || int'(x_out) != e.x || int'(y_out) != e.y || int'(colour_out) != e.c) begin
            bad++;
            $display("[TB] FAIL pixel got (%0d,%0d,%0d) want (%0d,%0d,%0d) isDone=%0d",
                     x_out, y_out, colour_out, e.x, e.y, e.c, e.isDone);
          end
        end
      end
      if (done) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL done got pulse want nothing");
        end else begin
          e = sb.pop_front();
          if (!e.isDone) begin
            bad++;
            $display("[TB] FAIL done got pulse want pixel (%0d,%0d,%0d)", e.x, e.y, e.c);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: the block's on-screen pixels in raster order, then done.
  task automatic pushBlock(input int x, input int y, input int c);
    for (int r = 0; r < BLK_H; r++) begin
      for (int k = 0; k < BLK_W; k++) begin
        if (x + k < SCR_W && y + r < SCR_H) begin
          sb.push_back('{isDone: 1'b0, x: x + k, y: y + r, c: c});
        end
      end
    end
    sb.push_back('{isDone: 1'b1, x: 0, y: 0, c: 0});
  endtask

  // Reference model: every screen pixel in colour 0, then done.
  task automatic pushClear();
    for (int r = 0; r < SCR_H; r++) begin
      for (int k = 0; k < SCR_W; k++) begin
        sb.push_back('{isDone: 1'b0, x: k, y: r, c: 0});
      end
    end
    sb.push_back('{isDone: 1'b1, x: 0, y: 0, c: 0});
  endtask

  // Wait for ready, present one request for one cycle, record expectations.
  task automatic applyStimulus(input bit doStart, input bit doClear, input int x, input int y, input int c);
    int n = 0;
    while (!ready_to_draw && n < 30000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_before_req", ready_to_draw, 1);
    enable_start = doStart;
    enable_clear = doClear;
    x_in = 8'(x);
    y_in = 7'(y);
    colour_in = 3'(c);
    if (doStart) pushBlock(x, y, c);
    if (doClear) pushClear();
    @(posedge clk); #1;
    enable_start = 1'b0;
    enable_clear = 1'b0;
  endtask

  // Block request with fixed-latency checks of first write and done.
  task automatic runTimedBlock(input string tag, input int x, input int y, input int c);
    applyStimulus(1'b1, 1'b0, x, y, c);
    checkOutput({tag, "_we_load"}, writeEn, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_we_n1"}, writeEn, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_we_first"}, writeEn, 1);
    checkOutput({tag, "_x_first"}, x_out, x);
    repeat (16) @(posedge clk);
    #1;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_we_done"}, writeEn, 0);
    checkOutput({tag, "_ready_done"}, ready_to_draw, 1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || !ready_to_draw) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int gaps;
    int doneCount;
    int n;
    int base;

    #3;
    checkOutput("rst_x", x_out, 0);
    checkOutput("rst_y", y_out, 0);
    checkOutput("rst_colour", colour_out, 0);
    checkOutput("rst_we", writeEn, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ready", ready_to_draw, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    runTimedBlock("basic", 10, 20, 5);
    runTimedBlock("clip", 158, 118, 6);
    waitIdle(100);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 7)));
    end
    waitIdle(1000);

    applyStimulus(1'b0, 1'b1, 0, 0, 0);
    waitIdle(20000);

    applyStimulus(1'b1, 1'b1, 40, 50, 2);
    gaps = 0;
    doneCount = 0;
    n = 0;
    while (doneCount < 2 && n < 20000) begin
      if (done) doneCount++;
      if (doneCount < 2 && ready_to_draw) gaps++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("pending_done_count", doneCount, 2);
    checkOutput("pending_idle_gaps", gaps, 0);
    waitIdle(100);

    applyStimulus(1'b0, 1'b1, 0, 0, 0);
    base = nWrites;
    n = 0;
    while (nWrites - base < 5000 && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("midclear_reached", (nWrites - base >= 5000) ? 1 : 0, 1);
    resetn = 1'b0;
    #1;
    checkOutput("midclear_rst_we", writeEn, 0);
    checkOutput("midclear_rst_ready", ready_to_draw, 1);
    checkOutput("midclear_rst_x", x_out, 0);
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    base = nWrites;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("post_rst_ready", ready_to_draw, 1);
    checkOutput("post_rst_writes", nWrites - base, 0);

`ifdef PLOT_STALL_EN
    applyStimulus(1'b1, 1'b0, 10, 20, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    plot_ready = 1'b0;
    checkOutput("stall_x_start", x_out, 11);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stall_x_held", x_out, 11);
    checkOutput("stall_we_held", writeEn, 1);
    @(posedge clk); #1;
    plot_ready = 1'b1;
    checkOutput("stall_x_end", x_out, 11);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("stall_done", done, 1);
    waitIdle(100);
`endif

    runTimedBlock("final", 0, 0, 7);
    waitIdle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
